fadd_share_arb: RTL and testbench



---
 rtl/fpu_pkg.sv | 16 +
 rtl/fadd_share_arb_rr_arbiter.sv | 49 ++++
 rtl/fadd_share_arb.sv | 140 ++++++++++++++
 tb/tb_fadd_share_arb.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: operand width, adder latency and the result entry
// carried from a shared adder back to its requesters.
package fpu_pkg;

   localparam int unsigned FP_W      = 32;
   localparam int unsigned FADD_LAT  = 2;
   // Widest tag any sharer needs (up to 8 requesters).
   localparam int unsigned TAG_W_MAX = 3;

   typedef struct packed {
      logic [TAG_W_MAX-1:0] tag;
      logic [FP_W-1:0]      y;
      logic                 ovf;
   } fadd_rsp_t;

endpackage

// File: rtl/fadd_share_arb_rr_arbiter.sv
// Round-robin arbiter with grant enable and registered last-grant pointer.
// Ports:
//   clk, rstn  clock, synchronous active-low reset
//   req        request vector
//   en         grant enable; no grant and pointer holds when low
//   gnt        one-hot grant (combinational from req/en)
//   gnt_idx    index of the granted requester
//   gnt_any    a grant is being given this cycle
module rr_arbiter #(
   parameter  int unsigned N  = 4,
   localparam int unsigned IW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic [N-1:0]  req,
   input  logic          en,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx,
   output logic          gnt_any
);

   logic [IW-1:0] ptr_q;
   logic [IW-1:0] ptr_d;
   logic [IW-1:0] cand;

   // Search upward from the slot after the last winner, wrapping to 0.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      cand    = '0;
      for (int unsigned off = 1; off <= N; off++) begin
         cand = IW'((32'(ptr_q) + off) % N);
         if (en && !gnt_any && req[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
         end
      end
      if (gnt_any) gnt[gnt_idx] = 1'b1;
      ptr_d = gnt_any ? gnt_idx : ptr_q;
   end

   // Reset to N-1 so requester 0 has first priority.
   always_ff @(posedge clk) begin
      if (!rstn) ptr_q <= IW'(N - 1);
      else       ptr_q <= ptr_d;
   end

endmodule

// File: rtl/fadd_share_arb.sv
// Shares one fixed-latency pipelined adder among NREQ requesters. Requests are
// granted round-robin under a credit limit, tagged through a shadow pipe, and
// results are queued in an ordered FIFO for a single response port.
// Ports:
//   clk, rstn          clock, synchronous active-low reset
//   req_valid/ready    per-requester handshake (ready is one-hot or zero)
//   req_x1/req_x2      packed operands, requester i at [32i+31:32i]
//   fadd_x1/x2         operands to the adder (0 when nothing issues)
//   fadd_y/fadd_ovf    adder result, valid LAT edges after issue
//   rsp_valid/ready    response handshake
//   rsp_tag/y/ovf      requester index, sum, overflow flag
module fadd_share_arb
   import fpu_pkg::*;
#(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned LAT   = FADD_LAT,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned TW    = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [FP_W*NREQ-1:0] req_x1,
   input  logic [FP_W*NREQ-1:0] req_x2,
   output logic [FP_W-1:0]      fadd_x1,
   output logic [FP_W-1:0]      fadd_x2,
   input  logic [FP_W-1:0]      fadd_y,
   input  logic                 fadd_ovf,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [TW-1:0]        rsp_tag,
   output logic [FP_W-1:0]      rsp_y,
   output logic                 rsp_ovf
);

   localparam int unsigned AW  = $clog2(NREQ);
   localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW  = $clog2(DEPTH + 1);
   localparam int unsigned IFW = $clog2(LAT + 1);

   logic [NREQ-1:0] gnt;
   logic [AW-1:0]   gnt_idx;
   logic            gnt_any;
   logic            can_issue;
   logic [IFW-1:0]  inflight;

   logic [LAT-1:0]  vld_q, vld_d;
   logic [TW-1:0]   tag_q [LAT];
   logic [TW-1:0]   tag_d [LAT];

   fadd_rsp_t       mem_q [DEPTH];
   fadd_rsp_t       mem_d [DEPTH];
   fadd_rsp_t       head;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            push;
   logic            pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Issue is also held off while in reset so nothing is accepted then.
   rr_arbiter #(.N(NREQ)) u_arb (
      .clk     (clk),
      .rstn    (rstn),
      .req     (req_valid),
      .en      (can_issue && rstn),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   assign req_ready = gnt;
   assign head      = mem_q[rd_ptr_q];
   assign rsp_valid = (count_q != '0);
   assign rsp_tag   = TW'(head.tag);
   assign rsp_y     = head.y;
   assign rsp_ovf   = head.ovf;
   assign push      = vld_q[LAT-1];
   assign pop       = rsp_valid && rsp_ready;

   // Credits, operand mux, tag pipe and FIFO next state.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < int'(LAT); i++) inflight = inflight + IFW'(vld_q[i]);
      // Conservative: a pop in this same cycle does not free a credit yet.
      can_issue = (32'(count_q) + 32'(inflight)) < DEPTH;

      fadd_x1 = '0;
      fadd_x2 = '0;
      if (gnt_any) begin
         fadd_x1 = req_x1[FP_W*gnt_idx +: FP_W];
         fadd_x2 = req_x2[FP_W*gnt_idx +: FP_W];
      end

      vld_d[0] = gnt_any;
      tag_d[0] = TW'(gnt_idx);
      for (int i = 1; i < int'(LAT); i++) begin
         vld_d[i] = vld_q[i-1];
         tag_d[i] = tag_q[i-1];
      end

      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q] = '{tag: TAG_W_MAX'(tag_q[LAT-1]), y: fadd_y, ovf: fadd_ovf};
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         vld_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < int'(LAT); i++)   tag_q[i] <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else begin
         vld_q    <= vld_d;
         tag_q    <= tag_d;
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Credits guarantee a slot for every result coming out of the adder.
   always_ff @(posedge clk) begin
      if (rstn) assert (!(push && (count_q == CW'(DEPTH))));
   end

endmodule

// File: tb/tb_fadd_share_arb.sv
module tb_fadd_share_arb;

   localparam int NREQ  = 4;
   localparam int LAT   = 2;
   localparam int DEPTH = 4;
   localparam int TW    = 2;

   logic                 clk = 1'b0;
   logic                 rstn;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [32*NREQ-1:0]   req_x1, req_x2;
   logic [31:0]          fadd_x1, fadd_x2, fadd_y;
   logic                 fadd_ovf;
   logic                 rsp_valid, rsp_ready;
   logic [TW-1:0]        rsp_tag;
   logic [31:0]          rsp_y;
   logic                 rsp_ovf;

   always #5 clk = ~clk;

   fadd_share_arb #(.NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH), .TW(TW)) dut (
      .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
      .req_x1(req_x1), .req_x2(req_x2), .fadd_x1(fadd_x1), .fadd_x2(fadd_x2),
      .fadd_y(fadd_y), .fadd_ovf(fadd_ovf), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_tag(rsp_tag), .rsp_y(rsp_y), .rsp_ovf(rsp_ovf)
   );

   // Single-precision value to real (normals only; zero exponent reads as 0).
   function automatic real f2r(input logic [31:0] a);
      logic [63:0] d;
      if (a[30:23] == 8'd0) return 0.0;
      d = {a[31], 11'(int'(a[30:23]) - 127 + 1023), a[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   // Reference adder: {ovf, y}; truncating round, flush to zero, inf on overflow.
   function automatic logic [32:0] fadd_ref(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] d;
      int e;
      d = $realtobits(f2r(a) + f2r(b));
      e = int'(d[62:52]);
      if (e == 0) return {1'b0, d[63], 31'd0};
      e = e - 1023 + 127;
      if (e >= 255) return {1'b1, d[63], 8'hFF, 23'd0};
      if (e <= 0) return {1'b0, d[63], 31'd0};
      return {1'b0, d[63], e[7:0], d[51:29]};
   endfunction

   // Behavioural fadd_p2: two register stages, same reset.
   logic [32:0] s1;
   always @(posedge clk) begin
      if (!rstn) begin
         s1 <= '0; fadd_y <= '0; fadd_ovf <= 1'b0;
      end else begin
         s1 <= fadd_ref(fadd_x1, fadd_x2);
         {fadd_ovf, fadd_y} <= s1;
      end
   end

   typedef struct {
      int          tag;
      logic [31:0] y;
      logic        ovf;
      int          rdy;
   } exp_t;

   exp_t            exp_q[$];
   int              n_checks = 0;
   int              n_fail   = 0;
   int              cyc      = 0;
   int              outstanding = 0;
   int              last_g   = NREQ - 1;
   int              n_issued = 0;
   logic            rst_seen = 1'b0;
   logic [NREQ-1:0] acc = '0;

   logic [NREQ-1:0] v    = '0;
   logic [31:0]     a1 [NREQ];
   logic [31:0]     a2 [NREQ];
   logic [NREQ-1:0] mask = '0;
   int              vprob = 0;
   int              rprob = 100;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   // Monitor/scoreboard: samples 1 ns before each rising edge.
   always @(negedge clk) begin
      int              eg;
      logic [NREQ-1:0] exp_rdy;
      logic            popped;
      logic [32:0]     r;
      exp_t            e;
      #4;
      cyc++;
      if (!rstn) begin
         check("rst_req_ready", 64'(req_ready), 64'(0));
         if (rst_seen) check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
         rst_seen    = 1'b1;
         exp_q.delete();
         outstanding = 0;
         last_g      = NREQ - 1;
         acc         = '0;
      end else begin
         rst_seen = 1'b0;
         popped   = 1'b0;
         if (exp_q.size() > 0 && cyc >= exp_q[0].rdy) begin
            check("rsp_valid", 64'(rsp_valid), 64'(1));
            if (rsp_valid) begin
               check("rsp_tag", 64'(rsp_tag), 64'(exp_q[0].tag));
               check("rsp_y", 64'(rsp_y), 64'(exp_q[0].y));
               check("rsp_ovf", 64'(rsp_ovf), 64'(exp_q[0].ovf));
               if (rsp_ready) begin
                  void'(exp_q.pop_front());
                  popped = 1'b1;
               end
            end
         end else begin
            check("rsp_valid_idle", 64'(rsp_valid), 64'(0));
         end

         eg = -1;
         if (outstanding < DEPTH)
            for (int off = 1; off <= NREQ; off++)
               if (eg < 0 && req_valid[(last_g + off) % NREQ]) eg = (last_g + off) % NREQ;
         exp_rdy = '0;
         if (eg >= 0) exp_rdy[eg] = 1'b1;
         check("req_ready", 64'(req_ready), 64'(exp_rdy));
         if (eg >= 0) begin
            check("fadd_x1", 64'(fadd_x1), 64'(req_x1[32*eg +: 32]));
            check("fadd_x2", 64'(fadd_x2), 64'(req_x2[32*eg +: 32]));
            r     = fadd_ref(req_x1[32*eg +: 32], req_x2[32*eg +: 32]);
            e.tag = eg;
            e.y   = r[31:0];
            e.ovf = r[32];
            e.rdy = cyc + LAT + 1;
            exp_q.push_back(e);
            outstanding++;
            n_issued++;
            last_g = eg;
         end else begin
            check("fadd_x_idle", 64'({fadd_x1, fadd_x2}), 64'(0));
         end
         if (popped) outstanding--;
         acc = req_ready & req_valid;
      end
   end

   function automatic logic [31:0] rand_fp();
      return {1'($urandom_range(0, 1)), 8'(100 + $urandom_range(0, 50)), 23'($urandom)};
   endfunction

   task automatic apply();
      req_valid = v;
      for (int i = 0; i < NREQ; i++) begin
         req_x1[32*i +: 32] = a1[i];
         req_x2[32*i +: 32] = a2[i];
      end
   endtask

   // Requesters hold valid and operands until accepted.
   task automatic drive_cycle();
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
         if (acc[i]) v[i] = 1'b0;
         if (!v[i] && mask[i] && ($urandom_range(0, 99) < 32'(vprob))) begin
            v[i]  = 1'b1;
            a1[i] = rand_fp();
            a2[i] = rand_fp();
         end
      end
      rsp_ready = (rprob >= 100) ? 1'b1 : ($urandom_range(0, 99) < 32'(rprob));
      apply();
   endtask

   task automatic run(input int n);
      repeat (n) drive_cycle();
   endtask

   task automatic put_op(input int i, input logic [31:0] x1, input logic [31:0] x2);
      @(negedge clk);
      for (int k = 0; k < NREQ; k++) if (acc[k]) v[k] = 1'b0;
      v[i]  = 1'b1;
      a1[i] = x1;
      a2[i] = x2;
      rsp_ready = 1'b1;
      apply();
   endtask

   task automatic do_reset(input int n);
      int sv;
      sv    = rprob;
      rprob = 0;
      drive_cycle();
      rstn = 1'b0;
      rsp_ready = 1'b0;
      run(n - 1);
      drive_cycle();
      rstn  = 1'b1;
      rprob = sv;
   endtask

   task automatic wait_drain(input string nm, input int maxc);
      mask  = '0;
      rprob = 100;
      for (int i = 0; i < maxc; i++) begin
         if (exp_q.size() == 0 && v == '0) break;
         drive_cycle();
      end
      check(nm, 64'(exp_q.size() == 0 && v == '0), 64'(1));
   endtask

   initial begin
      int base;
      rstn = 1'b0;
      rsp_ready = 1'b0;
      for (int i = 0; i < NREQ; i++) begin a1[i] = '0; a2[i] = '0; end
      apply();
      do_reset(3);

      put_op(0, 32'h3F800000, 32'h40000000);
      run(8);
      put_op(1, 32'h7F7FFFFF, 32'h7F7FFFFF);
      run(8);

      mask = '1; vprob = 100; rprob = 100;
      run(40);
      rprob = 0;
      run(12);
      rprob = 100;
      run(20);

      vprob = 50; rprob = 60;
      run(300);

      mask = NREQ'(4); vprob = 100; rprob = 50;
      run(40);
      mask = '1;
      run(10);

      wait_drain("drain_before_reset", 60);
      mask = '1; vprob = 100; rprob = 0;
      base = n_issued;
      for (int i = 0; i < 30; i++) begin
         if (n_issued - base >= 4) break;
         drive_cycle();
      end
      check("fill_before_reset", 64'(n_issued - base >= 4), 64'(1));
      do_reset(2);
      rprob = 100;
      run(30);

      vprob = 40; rprob = 30;
      run(150);
      wait_drain("final_drain", 200);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
